// File: rtl/mem_stage_unit.sv
// Memory stage of the 5-stage pipeline: loads, stores, push/pop against an internal data
// memory, stack pointer ownership, and the registered writeback bundle toward MEM/WB.
module mem_stage_unit #(
  parameter int              ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ALU_result,
  input  logic [15:0]       Rs_data,
  input  logic [15:0]       Rd_data,
  input  logic [2:0]        Rd,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              regWrite,
  input  logic              push,
  input  logic              pop,
  output logic [15:0]       wb_data,
  output logic [2:0]        Rd_wb,
  output logic              regWrite_wb,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       rd_data_reg;
  logic [15:0]       alu_reg;
  logic              sel_mem_reg;
  logic [2:0]        rd_wb_reg;
  logic              regwrite_wb_reg;
  logic [ADDR_W-1:0] sp_reg, sp_next;
  logic              ovf_reg, unf_reg;

  logic              push_ok, push_ovf, pop_sel, pop_ok, pop_unf, st_sel, ld_sel;
  logic              mem_we;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [15:0]       wdata;

  // Operation decode with fixed precedence push > pop > memWrite > memRead.
  always_comb begin
    push_ok  = push && (sp_reg != '0);
    push_ovf = push && (sp_reg == '0);
    pop_sel  = !push && pop;
    pop_ok   = pop_sel && (sp_reg != SP_INIT);
    pop_unf  = pop_sel && (sp_reg == SP_INIT);
    st_sel   = !push && !pop && memWrite;
    ld_sel   = !push && !pop && !memWrite && memRead;
  end

  always_comb begin
    mem_we  = !rst && (push_ok || st_sel);
    waddr   = push ? sp_reg : ALU_result[ADDR_W-1:0];
    wdata   = push ? Rd_data : Rs_data;
    raddr   = pop ? (sp_reg + 1'b1) : ALU_result[ADDR_W-1:0];
    sp_next = sp_reg;
    if (push_ok)
      sp_next = sp_reg - 1'b1;
    else if (pop_ok)
      sp_next = sp_reg + 1'b1;
  end

  // Read-first synchronous RAM; the read port register is left unreset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[waddr] <= wdata;
    rd_data_reg <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_reg         <= '0;
      sel_mem_reg     <= 1'b0;
      rd_wb_reg       <= '0;
      regwrite_wb_reg <= 1'b0;
      sp_reg          <= SP_INIT;
      ovf_reg         <= 1'b0;
      unf_reg         <= 1'b0;
    end else begin
      alu_reg         <= pop_unf ? 16'h0000 : ALU_result;
      sel_mem_reg     <= pop_ok || ld_sel;
      rd_wb_reg       <= Rd;
      regwrite_wb_reg <= regWrite && !(push_ovf || pop_unf);
      sp_reg          <= sp_next;
      ovf_reg         <= ovf_reg || push_ovf;
      unf_reg         <= unf_reg || pop_unf;
    end
  end

  assign wb_data     = sel_mem_reg ? rd_data_reg : alu_reg;
  assign Rd_wb       = rd_wb_reg;
  assign regWrite_wb = regwrite_wb_reg;
  assign sp          = sp_reg;
  assign stack_ovf   = ovf_reg;
  assign stack_unf   = unf_reg;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed scenarios plus random traffic, all compared against
// a behavioural model of the memory, stack and sticky flags.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ALU_result, Rs_data, Rd_data;
  logic [2:0]  Rd;
  logic        memRead, memWrite, regWrite, push, pop;
  logic [15:0] wb_data;
  logic [2:0]  Rd_wb;
  logic        regWrite_wb;
  logic [7:0]  sp;
  logic        stack_ovf, stack_unf;

  mem_stage_unit dut (
    .clk(clk), .rst(rst), .ALU_result(ALU_result), .Rs_data(Rs_data), .Rd_data(Rd_data),
    .Rd(Rd), .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .push(push),
    .pop(pop), .wb_data(wb_data), .Rd_wb(Rd_wb), .regWrite_wb(regWrite_wb), .sp(sp),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference state: memory image, stack pointer and flags.
  logic [15:0] m_mem [256];
  int          m_sp;
  bit          m_ovf, m_unf;
  logic [15:0] e_wb;
  logic [2:0]  e_rd;
  bit          e_rw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s txn=%0d got=%h exp=%h", tag, n_txn, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit psh, input bit pp, input bit mw, input bit mr,
                            input bit rw, input logic [15:0] alu, input logic [15:0] rs,
                            input logic [15:0] rdd, input logic [2:0] rd);
    int a;
    a = int'(alu[7:0]);
    if (r) begin
      e_wb = 16'h0; e_rd = 3'd0; e_rw = 1'b0;
      m_sp = 255; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    e_rd = rd;
    e_rw = rw;
    e_wb = alu;
    if (psh) begin
      if (m_sp == 0) begin
        m_ovf = 1'b1; e_rw = 1'b0;
      end else begin
        m_mem[m_sp] = rdd; m_sp = m_sp - 1;
      end
    end else if (pp) begin
      if (m_sp == 255) begin
        m_unf = 1'b1; e_rw = 1'b0; e_wb = 16'h0;
      end else begin
        m_sp = m_sp + 1; e_wb = m_mem[m_sp];
      end
    end else if (mw) begin
      m_mem[a] = rs;
    end else if (mr) begin
      e_wb = m_mem[a];
    end
  endtask

  task automatic do_op(input bit r, input bit psh, input bit pp, input bit mw, input bit mr,
                       input bit rw, input logic [15:0] alu, input logic [15:0] rs,
                       input logic [15:0] rdd, input logic [2:0] rd);
    rst = r; push = psh; pop = pp; memWrite = mw; memRead = mr; regWrite = rw;
    ALU_result = alu; Rs_data = rs; Rd_data = rdd; Rd = rd;
    @(posedge clk);
    #1;
    n_txn++;
    model_step(r, psh, pp, mw, mr, rw, alu, rs, rdd, rd);
    check("wb_data", 32'(wb_data), 32'(e_wb));
    check("Rd_wb", 32'(Rd_wb), 32'(e_rd));
    check("regWrite_wb", 32'(regWrite_wb), 32'(e_rw));
    check("sp", 32'(sp), 32'(m_sp));
    check("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    check("stack_unf", 32'(stack_unf), 32'(m_unf));
    $display("txn %0d rst=%0b push=%0b pop=%0b wr=%0b rd=%0b alu=%h -> wb=%h Rd_wb=%0d rw=%0b sp=%h ovf=%0b unf=%0b",
             n_txn, r, psh, pp, mw, mr, alu, wb_data, Rd_wb, regWrite_wb, sp, stack_ovf, stack_unf);
  endtask

  initial begin
    logic [15:0] v;
    {rst, push, pop, memWrite, memRead, regWrite} = '0;
    {ALU_result, Rs_data, Rd_data} = '0;
    Rd = '0;
    m_sp = 255;

    // Reset for two cycles.
    do_op(1, 0, 0, 0, 0, 1, 16'h1111, 16'h0, 16'h0, 3'd5);
    do_op(1, 0, 0, 0, 0, 1, 16'h2222, 16'h0, 16'h0, 3'd5);

    // Fill every location so the model image is fully defined; upper address bits are noise.
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      do_op(0, 0, 0, 1, 0, 0, {8'($urandom), 8'(i)}, v, 16'h0, 3'($urandom));
    end

    // Store then load through an alias address.
    do_op(0, 0, 0, 1, 0, 0, 16'h0010, 16'hBEEF, 16'h0, 3'd1);
    do_op(0, 0, 0, 0, 1, 1, 16'h0110, 16'h0, 16'h0, 3'd1);
    check("load_alias", 32'(wb_data), 32'h0000BEEF);

    // Push/pop round trip.
    do_op(0, 1, 0, 0, 0, 1, 16'h0, 16'h0, 16'h1234, 3'd3);
    do_op(0, 1, 0, 0, 0, 1, 16'h0, 16'h0, 16'h5678, 3'd3);
    do_op(0, 0, 1, 0, 0, 1, 16'h0, 16'h0, 16'h0, 3'd3);
    check("pop1", 32'(wb_data), 32'h00005678);
    do_op(0, 0, 1, 0, 0, 1, 16'h0, 16'h0, 16'h0, 3'd3);
    check("pop2", 32'(wb_data), 32'h00001234);

    // Underflow, then confirm the flag is sticky.
    do_op(0, 0, 1, 0, 0, 1, 16'h0, 16'h0, 16'h0, 3'd3);
    do_op(0, 1, 0, 0, 0, 1, 16'h0, 16'h0, 16'hAAAA, 3'd2);
    do_op(0, 0, 1, 0, 0, 1, 16'h0, 16'h0, 16'h0, 3'd2);
    check("unf_sticky", 32'(stack_unf), 32'd1);

    // Fill the stack until overflow, then confirm mem[0] survived.
    do_op(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0);
    do_op(0, 0, 0, 1, 0, 0, 16'h0000, 16'hA5A5, 16'h0, 3'd0);
    for (int i = 0; i < 256; i++)
      do_op(0, 1, 0, 0, 0, 1, 16'($urandom), 16'h0, 16'($urandom), 3'd4);
    check("ovf_set", 32'(stack_ovf), 32'd1);
    do_op(0, 0, 0, 0, 1, 1, 16'h0000, 16'h0, 16'h0, 3'd4);
    check("mem0_kept", 32'(wb_data), 32'h0000A5A5);

    // Push beats memWrite; reset during a pop restores SP_INIT.
    do_op(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0);
    do_op(0, 1, 0, 1, 0, 1, 16'h0040, 16'h7777, 16'h9999, 3'd6);
    do_op(0, 0, 0, 0, 1, 1, 16'h0040, 16'h0, 16'h0, 3'd6);
    do_op(0, 1, 0, 0, 0, 1, 16'h0, 16'h0, 16'h4242, 3'd6);
    do_op(1, 0, 1, 0, 0, 1, 16'h0, 16'h0, 16'h0, 3'd6);
    check("rst_pop_sp", 32'(sp), 32'h000000FF);

    // Random traffic with mixed, overlapping requests.
    for (int i = 0; i < 500; i++) begin
      do_op($urandom_range(0, 59) == 0,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40,
            1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
